// File: rtl/uart_rx_if.sv
// Output side of the UART receiver: received word on valid/ready plus 1-cycle error pulses.
// The receiver drives the master modport; the consumer uses the slave modport.
interface uart_rx_if #(
    parameter int unsigned data_width = 8
) ();
    logic [data_width-1:0] data_out;
    logic                  data_valid;
    logic                  data_ready;
    logic                  frame_err;
    logic                  overrun;
    logic                  parity_err;

    modport master (
        output data_out,
        output data_valid,
        output frame_err,
        output overrun,
        output parity_err,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  overrun,
        input  parity_err,
        output data_ready
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver with centre sampling and a valid/ready output holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx #(
    parameter int unsigned data_width = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      clk_en,
    input  logic      rx,
    uart_rx_if.master bus
);
    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(data_width) + 1;
    localparam logic [TickW-1:0] TickHalf = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(data_width - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    logic                  rx_meta_q, rx_s_q;
    state_e                state_q, state_d;
    logic [TickW-1:0]      tick_q, tick_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic [data_width-1:0] shift_q, shift_d;
    logic                  deliver_q, deliver_d;
    logic                  frame_err_q, frame_err_d;
    logic [data_width-1:0] data_out_q, data_out_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;
    logic                  par_bad;
`ifdef UART_RX_PARITY_EN
    logic                  par_bit_q, par_bit_d;
    logic                  perr_pend_q, perr_pend_d;
    logic                  parity_err_q, parity_err_d;

    assign par_bad = ^{shift_q, par_bit_q};
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            deliver_q   <= 1'b0;
            frame_err_q <= 1'b0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            deliver_q   <= deliver_d;
            frame_err_q <= frame_err_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bit_q    <= 1'b0;
            perr_pend_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bit_q    <= par_bit_d;
            perr_pend_q  <= perr_pend_d;
            parity_err_q <= parity_err_d;
        end
    end
`endif

    // Frame FSM: everything advances only on oversample ticks.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        deliver_d   = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d   = par_bit_q;
        perr_pend_d = 1'b0;
`endif
        if (clk_en) begin
            case (state_q)
                StIdle: begin
                    if (!rx_s_q) begin
                        state_d = StStart;
                        tick_d  = '0;
                    end
                end
                StStart: begin
                    if (tick_q == TickHalf) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_s_q ? StIdle : StData;
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end
                StData: begin
                    if (tick_q == TickLast) begin
                        // Shift in from the top so the first bit ends at position 0.
                        shift_d = {rx_s_q, shift_q[data_width-1:1]};
                        tick_d  = '0;
                        bit_d   = bit_q + BitW'(1);
                        if (bit_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
                            state_d = StParity;
`else
                            state_d = StStop;
`endif
                        end
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (tick_q == TickLast) begin
                        par_bit_d = rx_s_q;
                        tick_d    = '0;
                        state_d   = StStop;
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end
`endif
                StStop: begin
                    if (tick_q == TickLast) begin
                        tick_d  = '0;
                        state_d = StIdle;
                        if (!rx_s_q) begin
                            frame_err_d = 1'b1;
                        end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
                            perr_pend_d = 1'b1;
`endif
                        end else begin
                            deliver_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Holding register: a word arriving while the previous one is unaccepted is dropped.
    always_comb begin
        data_out_d = data_out_q;
        valid_d    = valid_q;
        overrun_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d = perr_pend_q;
`endif
        if (deliver_q) begin
            if (!valid_q || bus.data_ready) begin
                data_out_d = shift_q;
                valid_d    = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && bus.data_ready) begin
            valid_d = 1'b0;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a frame-level model queues the outcome each sent frame must produce,
// and a per-cycle monitor matches DUT output events against that queue.
module tb_uart_rx;
    localparam int unsigned DW     = 8;
    localparam int unsigned OS     = 16;
    localparam int unsigned DIV    = 4;
    localparam int unsigned BITCLK = OS * DIV;

    typedef enum int {KDeliver, KFrame, KParity, KOverrun} kind_e;
    typedef struct {
        kind_e        kind;
        logic [DW-1:0] word;
    } exp_t;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic clk_en = 1'b0;
    logic rx     = 1'b1;

    uart_rx_if #(.data_width(DW)) bus ();

    uart_rx #(
        .data_width(DW),
        .OVERSAMPLE(OS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clk_en(clk_en),
        .rx    (rx),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned en_cnt = 0;
    always begin
        @(posedge clk);
        #1;
        en_cnt++;
        clk_en = (en_cnt % DIV == 0);
    end

    exp_t          exp_q[$];
    bit            held = 1'b0;
    int            n_checks = 0;
    int            n_errors = 0;
    int            n_words = 0;
    int            n_frame = 0;
    int            n_ovr = 0;
    int            n_par = 0;
    logic [DW-1:0] last_word = '0;
    logic [DW-1:0] cur = '0;
    bit            prev_valid = 1'b0;
    bit            prev_acc = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic pop_expect(input kind_e k, input logic [DW-1:0] w, input string name);
        chk({name, "_expected"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            chk({name, "_kind"}, 32'(exp_q[0].kind), 32'(k));
            if (k == KDeliver) chk("delivered_word", 32'(w), 32'(exp_q[0].word));
            void'(exp_q.pop_front());
        end
    endtask

    // Monitor: every output event must be the next outcome the model predicted.
    always @(negedge clk) begin
        if (!rst) begin
            prev_valid = 1'b0;
            prev_acc   = 1'b0;
        end else begin
            if (bus.data_valid && (!prev_valid || prev_acc)) begin
                n_words++;
                last_word = bus.data_out;
                cur       = bus.data_out;
                pop_expect(KDeliver, bus.data_out, "deliver");
            end else if (bus.data_valid) begin
                chk("data_out_stable", 32'(bus.data_out), 32'(cur));
            end
            if (bus.frame_err) begin
                n_frame++;
                pop_expect(KFrame, '0, "frame_err");
            end
            if (bus.overrun) begin
                n_ovr++;
                pop_expect(KOverrun, '0, "overrun");
            end
            if (bus.parity_err) begin
                n_par++;
                pop_expect(KParity, '0, "parity_err");
            end
            prev_valid = bus.data_valid;
            prev_acc   = bus.data_valid && bus.data_ready;
        end
    end

    task automatic wait_bit();
        repeat (BITCLK) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic stop_b, input logic par_b);
        exp_t e;
        logic bad;
        bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        bad = ^{d, par_b};
`endif
        e.word = d;
        if (!stop_b) e.kind = KFrame;
        else if (bad) e.kind = KParity;
        else if (held) e.kind = KOverrun;
        else begin
            e.kind = KDeliver;
            if (!bus.data_ready) held = 1'b1;
        end
        exp_q.push_back(e);
        rx = 1'b0;
        wait_bit();
        for (int i = 0; i < int'(DW); i++) begin
            rx = d[i];
            wait_bit();
        end
`ifdef UART_RX_PARITY_EN
        rx = par_b;
        wait_bit();
`endif
        rx = stop_b;
        wait_bit();
        rx = 1'b1;
        wait_bit();
        chk("events_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_outputs_clear(input string tag);
        chk({tag, "_data_valid"}, 32'(bus.data_valid), 32'd0);
        chk({tag, "_data_out"}, 32'(bus.data_out), 32'd0);
        chk({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
        chk({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
        chk({tag, "_parity_err"}, 32'(bus.parity_err), 32'd0);
    endtask

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.data_ready = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_outputs_clear("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        wait_bit();

        send_frame(8'h55, 1'b1, ^8'h55);
        chk("first_word", 32'(last_word), 32'h55);
        send_frame(8'hA3, 1'b1, ^8'hA3);
        chk("second_word", 32'(last_word), 32'hA3);

        // Start glitch shorter than half a bit.
        rx = 1'b0;
        repeat (3 * DIV) @(posedge clk);
        #1;
        rx = 1'b1;
        wait_bit();
        wait_bit();
        chk("glitch_words", 32'(n_words), 32'd2);
        chk("glitch_frame_err", 32'(n_frame), 32'd0);

        send_frame(8'h3C, 1'b0, ^8'h3C);
        chk("framing_count", 32'(n_frame), 32'd1);
        chk("framing_no_word", 32'(n_words), 32'd2);
        send_frame(8'h81, 1'b1, ^8'h81);
        chk("after_framing_word", 32'(last_word), 32'h81);

        bus.data_ready = 1'b0;
        send_frame(8'h11, 1'b1, ^8'h11);
        chk("held_valid", 32'(bus.data_valid), 32'd1);
        chk("held_word", 32'(bus.data_out), 32'h11);
        send_frame(8'h22, 1'b1, ^8'h22);
        chk("overrun_count", 32'(n_ovr), 32'd1);
        chk("overrun_keeps_word", 32'(bus.data_out), 32'h11);
        bus.data_ready = 1'b1;
        held = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("accepted_clears_valid", 32'(bus.data_valid), 32'd0);

        // Leave a word pending, then reset in the middle of the next frame.
        bus.data_ready = 1'b0;
        send_frame(8'h5A, 1'b1, ^8'h5A);
        chk("pending_valid", 32'(bus.data_valid), 32'd1);
        rx = 1'b0;
        wait_bit();
        for (int i = 0; i < 3; i++) begin
            rx = 1'b0;
            wait_bit();
        end
        repeat (BITCLK / 2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_outputs_clear("midframe_reset");
        rx = 1'b1;
        exp_q.delete();
        held = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.data_ready = 1'b1;
        wait_bit();
        wait_bit();
        send_frame(8'h0F, 1'b1, ^8'h0F);
        chk("after_reset_word", 32'(last_word), 32'h0F);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        chk("parity_good_word", 32'(last_word), 32'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        chk("parity_err_count", 32'(n_par), 32'd1);
        chk("words_total", 32'(n_words), 32'd7);
`else
        chk("parity_err_count", 32'(n_par), 32'd0);
        chk("words_total", 32'(n_words), 32'd6);
`endif
        chk("frame_err_total", 32'(n_frame), 32'd1);
        chk("overrun_total", 32'(n_ovr), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
